// File: rtl/iq_sample_fifo.sv
// First-word-fall-through FIFO packing 16-bit I/Q pairs into {I,Q} words, with a
// priming gate that holds rd_dr low until PRIME_THRESH words are buffered.
// Optional feature macro: IQ_OVF_COUNT_EN adds a saturating ovf_count output.
//
// Read handshake: rd_data is valid whenever rd_dr=1; a pop happens on any
// edge where rd_en=1 and rd_dr=1. rd_en while rd_dr=0 is ignored. Upstream
// has no backpressure: a write while full is dropped and flagged.
module iq_sample_fifo #(
  parameter int ADDR_W       = 9,
  parameter int PRIME_THRESH = 366
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       in_i,
  input  logic [15:0]       in_q,
  input  logic              in_valid,
  input  logic              rd_en,
  input  logic              ovf_clr,
  output logic [31:0]       rd_data,
  output logic              rd_dr,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
`ifdef IQ_OVF_COUNT_EN
  output logic [15:0]       ovf_count,
`endif
  output logic              gate_streaming
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PRIME_L  = (ADDR_W+1)'(PRIME_THRESH);
  localparam logic [ADDR_W:0] FULL_XOR = {1'b1, {ADDR_W{1'b0}}};

  if (PRIME_THRESH > DEPTH) begin : g_bad_thresh
    $error("iq_sample_fifo: PRIME_THRESH exceeds FIFO depth");
  end

  typedef enum logic {
    PRIMING   = 1'b0,
    STREAMING = 1'b1
  } gate_e;

  gate_e               state_q, state_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         mem_q [DEPTH];

  logic                full;
  logic                wr_acc;
  logic                drop;
  logic                pop;
  logic [31:0]         wr_word;

  // Pointers carry an extra MSB: equal low bits with differing MSB means full.
  assign full    = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
  assign wr_acc  = in_valid & ~full;
  assign drop    = in_valid & full;
  assign pop     = rd_en & rd_dr;
  assign wr_word = {in_i, in_q};

  assign rd_dr          = (state_q == STREAMING) && (level_q != '0);
  assign rd_data        = rd_data_q;
  assign level          = level_q;
  assign overflow       = ovf_q;
  assign gate_streaming = (state_q == STREAMING);

  always_comb begin
    wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(wr_acc);
    rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(pop);
    level_d  = level_q;
    case ({wr_acc, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Registered head: the word at rd_ptr_d, bypassing a same-cycle write that
  // lands exactly on the new head (write into empty, or pop of the last word).
  always_comb begin
    rd_data_d = rd_data_q;
    if (level_d != '0) begin
      if (wr_acc && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0])) begin
        rd_data_d = wr_word;
      end else begin
        rd_data_d = mem_q[rd_ptr_d[ADDR_W-1:0]];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIMING:   if (level_d >= PRIME_L) state_d = STREAMING;
      STREAMING: if (level_d == '0)      state_d = PRIMING;
      default:   state_d = PRIMING;
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PRIMING;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_word;
    end
  end

`ifdef IQ_OVF_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drop) begin
      if (ovf_clr) begin
        cnt_d = 16'd1;
      end else if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end else if (ovf_clr) begin
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_count = cnt_q;
`endif

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Self-checking bench for iq_sample_fifo: an independent level/gate/overflow
// model plus an expected-word queue compared against the head on every ready cycle.
module tb_iq_sample_fifo;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int THRESH = 366;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       in_i, in_q;
  logic              in_valid, rd_en, ovf_clr;
  logic [31:0]       rd_data;
  logic              rd_dr;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              gate_streaming;
`ifdef IQ_OVF_COUNT_EN
  logic [15:0]       ovf_count;
`endif

  iq_sample_fifo #(.ADDR_W(ADDR_W), .PRIME_THRESH(THRESH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_i           (in_i),
    .in_q           (in_q),
    .in_valid       (in_valid),
    .rd_en          (rd_en),
    .ovf_clr        (ovf_clr),
    .rd_data        (rd_data),
    .rd_dr          (rd_dr),
    .level          (level),
    .overflow       (overflow),
`ifdef IQ_OVF_COUNT_EN
    .ovf_count      (ovf_count),
`endif
    .gate_streaming (gate_streaming)
  );

  always #5 clk = ~clk;

  // Scoreboard and reference model
  logic [31:0] exp_q[$];
  int          m_level;
  logic        m_stream;
  logic        m_ovf;
  int          m_cnt;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_level  = 0;
    m_stream = 1'b0;
    m_ovf    = 1'b0;
    m_cnt    = 0;
  endtask

  // One clock cycle: check outputs, drive inputs, step the model across the edge.
  task automatic cycle(input logic v, input logic [15:0] i, input logic [15:0] q,
                       input logic re, input logic clr);
    logic m_rd_dr, m_full, wr, pop;
    m_rd_dr = m_stream && (m_level != 0);
    chk("rd_dr", 32'(rd_dr), 32'(m_rd_dr));
    chk("level", 32'(level), 32'(m_level));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("state", 32'(gate_streaming), 32'(m_stream));
    if (m_rd_dr) chk("rd_data", rd_data, exp_q[0]);
`ifdef IQ_OVF_COUNT_EN
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
`endif
    in_valid = v;
    in_i     = i;
    in_q     = q;
    rd_en    = re;
    ovf_clr  = clr;
    @(posedge clk);
    m_full = (m_level == DEPTH);
    wr     = v && !m_full;
    pop    = re && m_rd_dr;
    if (pop) void'(exp_q.pop_front());
    if (wr) exp_q.push_back({i, q});
    if (v && m_full) begin
      m_ovf = 1'b1;
      m_cnt = clr ? 1 : ((m_cnt == 65535) ? m_cnt : m_cnt + 1);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    m_level = m_level + (wr ? 1 : 0) - (pop ? 1 : 0);
    if (!m_stream && m_level >= THRESH) m_stream = 1'b1;
    else if (m_stream && m_level == 0) m_stream = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom_range(0, 65535));
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_i = '0; in_q = '0; rd_en = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #12;
    chk("rst_rd_dr", 32'(rd_dr), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Prime and ordering: I=1..366, Q=~I, rd_en held high throughout
    for (int k = 1; k <= THRESH; k++) begin
      if (k == THRESH) begin
        chk("t1_level365", 32'(level), 32'd365);
        chk("t1_rd_dr365", 32'(rd_dr), 32'd0);
      end
      cycle(1'b1, 16'(k), ~16'(k), 1'b1, 1'b0);
    end
    chk("t1_open", 32'(rd_dr), 32'd1);
    chk("t2_first", rd_data, 32'h0001FFFE);
    repeat (370) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("t2_drained_rd_dr", 32'(rd_dr), 32'd0);
    chk("t2_priming", 32'(gate_streaming), 32'd0);

    // Overflow: 515 writes with no reads
    repeat (515) cycle(1'b1, rnd16(), rnd16(), 1'b0, 1'b0);
    chk("t3_level", 32'(level), 32'd512);
    chk("t3_overflow", 32'(overflow), 32'd1);
`ifdef IQ_OVF_COUNT_EN
    chk("t3_ovf_count", 32'(ovf_count), 32'd3);
`endif

    // Full with simultaneous write and pop: write dropped
    cycle(1'b1, rnd16(), rnd16(), 1'b1, 1'b0);
    chk("t4_level", 32'(level), 32'd511);
    chk("t4_overflow", 32'(overflow), 32'd1);

    // Refill to full, then drop together with clear (set wins), then clear alone
    cycle(1'b1, rnd16(), rnd16(), 1'b0, 1'b0);
    cycle(1'b1, rnd16(), rnd16(), 1'b0, 1'b1);
    chk("clr_vs_drop", 32'(overflow), 32'd1);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("clr_alone", 32'(overflow), 32'd0);

    // Steady streaming at level 400
    repeat (112) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("t5_level_start", 32'(level), 32'd400);
    repeat (1000) cycle(1'b1, rnd16(), rnd16(), 1'b1, 1'b0);
    chk("t5_level_end", 32'(level), 32'd400);
    chk("t5_no_drop", 32'(overflow), 32'd0);

    // Reset mid-stream at level 200
    repeat (200) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("t6_level_pre", 32'(level), 32'd200);
    #2 rst = 1'b1;
    #1;
    chk("t6_rd_dr", 32'(rd_dr), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    model_reset();
    in_valid = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (365) cycle(1'b1, rnd16(), rnd16(), 1'b1, 1'b0);
    chk("t6_still_gated", 32'(rd_dr), 32'd0);
    cycle(1'b1, rnd16(), rnd16(), 1'b1, 1'b0);
    chk("t6_reopen", 32'(rd_dr), 32'd1);
    repeat (370) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("t6_drained", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
